fwd_hazard_unit: RTL and testbench

- Parametrised successor of the single-pair bypass detector.
- Tracks up to DEPTH in-flight producer instructions in an internal shift pipeline (stage 1 = youngest, just issued; stage DEPTH = last stage before register-file write).
- Compares both source operands of the decode-stage instruction against all tracked producers, youngest first, and forwards the newest value or the register-file value.
- Raises a stall when the newest matching producer has not yet produced its result (load-use and multi-cycle ops); sits between decode and the execute pipeline.

---
 rtl/fwd_hazard_unit.sv | 181 ++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand bypass and hazard detector: tracks DEPTH in-flight producers and resolves
// both decode-stage source operands to the newest pipeline value or the register file.
module fwd_hazard_unit #(
    parameter int unsigned DEPTH              = 3,
    parameter int unsigned XLEN               = 32,
    parameter int unsigned REG_BITS           = 5,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             dec_ir_i,
    input  logic                    issue_vld_i,
    input  logic                    hold_i,
    input  logic                    flush_i,
    input  logic [DEPTH-1:0]        res_vld_i,
    input  logic [DEPTH*XLEN-1:0]   res_data_i,
    input  logic [XLEN-1:0]         rf_data1_i,
    input  logic [XLEN-1:0]         rf_data2_i,
    output logic [1:0]              fwd_o,
    output logic [XLEN-1:0]         data1_o,
    output logic [XLEN-1:0]         data2_o,
    output logic                    stall_o,
    output logic [15:0]             stall_cnt_o
);

    localparam int unsigned CNT_W = 16;

    localparam logic [3:0] OP_LW    = 4'd0;
    localparam logic [3:0] OP_SW    = 4'd1;
    localparam logic [3:0] OP_LI    = 4'd2;
    localparam logic [3:0] OP_ADDU  = 4'd3;
    localparam logic [3:0] OP_ADDIU = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_BGE   = 4'd7;
    localparam logic [3:0] OP_MULI  = 4'd9;

    // Per-stage producer state; index 0 is stage 1 (youngest)
    logic                vld_q  [DEPTH];
    logic [REG_BITS-1:0] dest_q [DEPTH];
    logic                rdy_q  [DEPTH];
    logic [XLEN-1:0]     data_q [DEPTH];
    logic                vld_d  [DEPTH];
    logic [REG_BITS-1:0] dest_d [DEPTH];
    logic                rdy_d  [DEPTH];
    logic [XLEN-1:0]     data_d [DEPTH];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic [3:0]          opcode_c;
    logic [REG_BITS-1:0] fld_a_c;
    logic [REG_BITS-1:0] fld_b_c;
    logic [REG_BITS-1:0] fld_c_c;
    logic [REG_BITS-1:0] src1_c;
    logic [REG_BITS-1:0] src2_c;
    logic                src1_vld_c;
    logic                src2_vld_c;
    logic                writer_c;
    logic                hit1_c;
    logic                hit2_c;
    logic                avail1_c;
    logic                avail2_c;
    logic [XLEN-1:0]     fdata1_c;
    logic [XLEN-1:0]     fdata2_c;
    logic                unused_imm_c;

    assign opcode_c     = dec_ir_i[31:28];
    assign fld_a_c      = REG_BITS'(dec_ir_i[27:23]);
    assign fld_b_c      = REG_BITS'(dec_ir_i[22:18]);
    assign fld_c_c      = REG_BITS'(dec_ir_i[17:13]);
    assign unused_imm_c = ^dec_ir_i[12:0];

    // Instruction decode: which fields are sources, and whether it writes field A
    always_comb begin
        src1_c     = fld_b_c;
        src2_c     = fld_c_c;
        src1_vld_c = 1'b0;
        src2_vld_c = 1'b0;
        writer_c   = 1'b0;
        case (opcode_c)
            OP_LW, OP_ADDIU, OP_SLL, OP_MULI: begin
                src1_vld_c = 1'b1;
                writer_c   = 1'b1;
            end
            OP_ADDU, OP_MUL: begin
                src1_vld_c = 1'b1;
                src2_vld_c = 1'b1;
                writer_c   = 1'b1;
            end
            OP_SW, OP_BGE: begin
                src1_c     = fld_a_c;
                src2_c     = fld_b_c;
                src1_vld_c = 1'b1;
                src2_vld_c = 1'b1;
            end
            OP_LI:   writer_c = 1'b1;
            default: ;
        endcase
    end

    // Scan oldest to youngest so the youngest matching producer overwrites older ones
    always_comb begin
        hit1_c   = 1'b0;
        hit2_c   = 1'b0;
        avail1_c = 1'b0;
        avail2_c = 1'b0;
        fdata1_c = '0;
        fdata2_c = '0;
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            if (src1_vld_c && vld_q[s] && (dest_q[s] == src1_c)) begin
                hit1_c   = 1'b1;
                avail1_c = rdy_q[s] | res_vld_i[s];
                fdata1_c = res_vld_i[s] ? res_data_i[s*XLEN +: XLEN] : data_q[s];
            end
            if (src2_vld_c && vld_q[s] && (dest_q[s] == src2_c)) begin
                hit2_c   = 1'b1;
                avail2_c = rdy_q[s] | res_vld_i[s];
                fdata2_c = res_vld_i[s] ? res_data_i[s*XLEN +: XLEN] : data_q[s];
            end
        end
    end

    assign fwd_o       = {hit2_c & avail2_c, hit1_c & avail1_c};
    assign data1_o     = fwd_o[0] ? fdata1_c : rf_data1_i;
    assign data2_o     = fwd_o[1] ? fdata2_c : rf_data2_i;
    assign stall_o     = (hit1_c & ~avail1_c) | (hit2_c & ~avail2_c);
    assign stall_cnt_o = cnt_q;

    // Next state: flush clears, hold captures results in place, otherwise shift
    always_comb begin
        vld_d  = vld_q;
        dest_d = dest_q;
        rdy_d  = rdy_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            for (int s = 0; s < int'(DEPTH); s++) vld_d[s] = 1'b0;
        end else if (hold_i) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (res_vld_i[s]) begin
                    rdy_d[s]  = 1'b1;
                    data_d[s] = res_data_i[s*XLEN +: XLEN];
                end
            end
        end else begin
            for (int s = 1; s < int'(DEPTH); s++) begin
                vld_d[s]  = vld_q[s-1];
                dest_d[s] = dest_q[s-1];
                rdy_d[s]  = rdy_q[s-1] | res_vld_i[s-1];
                data_d[s] = res_vld_i[s-1] ? res_data_i[(s-1)*XLEN +: XLEN] : data_q[s-1];
            end
            vld_d[0]  = issue_vld_i & ~stall_o & writer_c
                      & ~(ZERO_REG_HARDWIRED & (fld_a_c == '0));
            dest_d[0] = fld_a_c;
            rdy_d[0]  = 1'b0;
            data_d[0] = '0;
        end
        if (!flush_i && !hold_i && stall_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                vld_q[s]  <= 1'b0;
                dest_q[s] <= '0;
                rdy_q[s]  <= 1'b0;
                data_q[s] <= '0;
            end
            cnt_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dest_q <= dest_d;
            rdy_q  <= rdy_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a cycle-by-cycle vector table plus
// hand-written flush, hold and reset-mid-stall sequences.
module tb_fwd_hazard_unit;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned XLEN  = 32;
    localparam int          NV    = 22;

    localparam logic [3:0] LW = 4'd0, SW = 4'd1, LI = 4'd2, ADDU = 4'd3, ADDIU = 4'd4;
    localparam logic [3:0] MUL = 4'd6, BGE = 4'd7, J = 4'd8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           ir;
    logic                  issue, hold, flush;
    logic [DEPTH-1:0]      res_vld;
    logic [DEPTH*XLEN-1:0] res_data;
    logic [XLEN-1:0]       rf1, rf2;
    logic [1:0]            fwd;
    logic [XLEN-1:0]       d1, d2;
    logic                  stall;
    logic [15:0]           cnt;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_BITS(5), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .dec_ir_i(ir), .issue_vld_i(issue), .hold_i(hold),
        .flush_i(flush), .res_vld_i(res_vld), .res_data_i(res_data),
        .rf_data1_i(rf1), .rf_data2_i(rf2), .fwd_o(fwd), .data1_o(d1), .data2_o(d2),
        .stall_o(stall), .stall_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic        issue;
        logic [2:0]  rv;
        logic [31:0] rd;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [1:0]  e_fwd;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_stall;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] enc(logic [3:0] op, logic [4:0] a, logic [4:0] b, logic [4:0] c);
        return {op, a, b, c, 13'h0};
    endfunction

    function automatic vec_t mk(logic [31:0] i, logic iss, logic [2:0] rv, logic [31:0] rd,
                                logic [31:0] r1, logic [31:0] r2, logic [1:0] ef,
                                logic [31:0] e1, logic [31:0] e2, logic es, logic [15:0] ec);
        vec_t v;
        v.ir = i; v.issue = iss; v.rv = rv; v.rd = rd; v.rf1 = r1; v.rf2 = r2;
        v.e_fwd = ef; v.e_d1 = e1; v.e_d2 = e2; v.e_stall = es; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [1:0] ef, logic [31:0] e1, logic [31:0] e2,
                             logic es, logic [15:0] ec);
        check({tag, ".fwd"},   32'(fwd),   32'(ef));
        check({tag, ".d1"},    d1,         e1);
        check({tag, ".d2"},    d2,         e2);
        check({tag, ".stall"}, 32'(stall), 32'(es));
        check({tag, ".cnt"},   32'(cnt),   32'(ec));
    endtask

    task automatic idle();
        ir = enc(J, 5'd0, 5'd0, 5'd0); issue = 1'b0; hold = 1'b0; flush = 1'b0;
        res_vld = '0; res_data = '0; rf1 = 32'hAAAA; rf2 = 32'hBBBB;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle table; pipeline state carries from one row to the next
        vecs[0]  = mk(enc(ADDU, 3, 1, 2),  1, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 0);
        vecs[1]  = mk(enc(ADDU, 5, 3, 3),  0, 3'b001, 32'h1234, 32'hAAAA, 32'hBBBB, 2'b11, 32'h1234, 32'h1234, 0, 0);
        vecs[2]  = mk(enc(ADDU, 5, 3, 3),  0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b11, 32'h1234, 32'h1234, 0, 0);
        vecs[3]  = mk(enc(ADDU, 5, 3, 3),  0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b11, 32'h1234, 32'h1234, 0, 0);
        vecs[4]  = mk(enc(ADDU, 5, 3, 3),  0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 0);
        vecs[5]  = mk(enc(LW, 4, 1, 0),    1, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 0);
        vecs[6]  = mk(enc(ADDIU, 6, 4, 0), 1, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 1, 0);
        vecs[7]  = mk(enc(ADDIU, 6, 4, 0), 1, 3'b010, 32'hBEEF, 32'hAAAA, 32'hBBBB, 2'b01, 32'hBEEF, 32'hBBBB, 0, 1);
        vecs[8]  = mk(enc(J, 0, 0, 0),     0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[9]  = mk(enc(LI, 7, 0, 0),    1, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[10] = mk(enc(LI, 7, 0, 0),    1, 3'b001, 32'h11, 32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[11] = mk(enc(BGE, 7, 7, 0),   0, 3'b001, 32'h22, 32'hAAAA, 32'hBBBB, 2'b11, 32'h22,   32'h22,   0, 1);
        vecs[12] = mk(enc(BGE, 7, 7, 0),   0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b11, 32'h22,   32'h22,   0, 1);
        vecs[13] = mk(enc(BGE, 7, 7, 0),   0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b11, 32'h22,   32'h22,   0, 1);
        vecs[14] = mk(enc(BGE, 7, 7, 0),   0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[15] = mk(enc(LI, 0, 0, 0),    1, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[16] = mk(enc(ADDU, 1, 0, 0),  0, 3'b000, 0,      32'hAAAA, 32'hBBBB, 2'b00, 32'hAAAA, 32'hBBBB, 0, 1);
        vecs[17] = mk(enc(MUL, 9, 1, 2),   1, 3'b000, 0,      32'h1111, 32'h2222, 2'b00, 32'h1111, 32'h2222, 0, 1);
        vecs[18] = mk(enc(SW, 2, 9, 0),    1, 3'b000, 0,      32'h1111, 32'h2222, 2'b00, 32'h1111, 32'h2222, 1, 1);
        vecs[19] = mk(enc(SW, 2, 9, 0),    1, 3'b000, 0,      32'h1111, 32'h2222, 2'b00, 32'h1111, 32'h2222, 1, 2);
        vecs[20] = mk(enc(SW, 2, 9, 0),    1, 3'b100, 32'h9999, 32'h1111, 32'h2222, 2'b10, 32'h1111, 32'h9999, 0, 3);
        vecs[21] = mk(enc(SW, 2, 9, 0),    0, 3'b000, 0,      32'h1111, 32'h2222, 2'b00, 32'h1111, 32'h2222, 0, 3);

        // Reset with garbage on the control inputs
        idle();
        rst = 1'b1; ir = 32'h3A5C_F00D; issue = 1'b1; res_vld = 3'b111; res_data = {3{32'hDEAD_BEEF}};
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'b00, 32'hAAAA, 32'hBBBB, 1'b0, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            idle();
            ir = vecs[i].ir; issue = vecs[i].issue; res_vld = vecs[i].rv;
            res_data = {3{vecs[i].rd}}; rf1 = vecs[i].rf1; rf2 = vecs[i].rf2;
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_fwd, vecs[i].e_d1, vecs[i].e_d2,
                      vecs[i].e_stall, vecs[i].e_cnt);
            tick();
        end

        // Flush squashes a pending load and the instruction issuing alongside it
        idle(); ir = enc(LW, 4, 1, 0); issue = 1'b1; tick();
        idle(); ir = enc(ADDIU, 6, 4, 0); issue = 1'b1; flush = 1'b1; #1;
        check("flush.pre_stall", 32'(stall), 32'd1);
        tick();
        idle(); ir = enc(ADDIU, 6, 4, 0); #1;
        check_all("flush.post", 2'b00, 32'hAAAA, 32'hBBBB, 1'b0, 16'd3);
        idle(); ir = enc(LI, 8, 0, 0); issue = 1'b1; flush = 1'b1; tick();
        idle(); ir = enc(ADDU, 1, 8, 8); #1;
        check_all("flush.issue", 2'b00, 32'hAAAA, 32'hBBBB, 1'b0, 16'd3);
        tick();

        // Hold freezes the pipeline and the counter but still captures results
        idle(); ir = enc(LW, 4, 1, 0); issue = 1'b1; tick();
        idle(); ir = enc(ADDIU, 6, 4, 0); issue = 1'b1; hold = 1'b1; #1;
        check_all("hold.c1", 2'b00, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3);
        tick();
        #1;
        check_all("hold.c2", 2'b00, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3);
        tick();
        res_vld = 3'b001; res_data = {3{32'h5555}}; #1;
        check_all("hold.c3", 2'b01, 32'h5555, 32'hBBBB, 1'b0, 16'd3);
        tick();
        hold = 1'b0; res_vld = '0; res_data = '0; #1;
        check_all("hold.c4", 2'b01, 32'h5555, 32'hBBBB, 1'b0, 16'd3);
        tick();
        idle(); tick();

        // Reset in the middle of a load-use stall
        idle(); ir = enc(LW, 4, 1, 0); issue = 1'b1; tick();
        idle(); ir = enc(ADDIU, 6, 4, 0); issue = 1'b1; #1;
        check_all("rst.stall", 2'b00, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3);
        tick();
        rst = 1'b1; #1;
        check_all("rst.pre", 2'b00, 32'hAAAA, 32'hBBBB, 1'b1, 16'd4);
        tick();
        rst = 1'b0; #1;
        check_all("rst.post", 2'b00, 32'hAAAA, 32'hBBBB, 1'b0, 16'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
